// File: rtl/branch_update_queue_pkg.sv
// Shared predictor types for the branch update queue: executed-branch result,
// BTB entry layout, PHT counter, and the address-to-BTB field helpers.
package branch_update_queue_pkg;

  localparam int CONF_BTB_ENTRY_NUM = 2048;
  localparam int CONF_PHT_ENTRY_NUM = 2048;

  localparam int ADDR_WIDTH                 = 32;
  localparam int BTB_ENTRY_INDEX_BITS       = $clog2(CONF_BTB_ENTRY_NUM);
  localparam int BTB_TAG_WIDTH              = ADDR_WIDTH - BTB_ENTRY_INDEX_BITS - 2;
  localparam int BTB_CONTENTS_ADDR_WIDTH    = ADDR_WIDTH - 2;
  localparam int BRANCH_GLOBAL_HISTORY_BITS = 10;
  localparam int PHT_ENTRY_WIDTH            = 2;

  typedef logic [ADDR_WIDTH-1:0]                 AddrPath;
  typedef logic [BTB_TAG_WIDTH-1:0]              BTB_TagPath;
  typedef logic [BTB_CONTENTS_ADDR_WIDTH-1:0]    BTB_AddrPath;
  typedef logic [BRANCH_GLOBAL_HISTORY_BITS-1:0] BranchGlobalHistoryPath;
  typedef logic [PHT_ENTRY_WIDTH-1:0]            PHT_EntryPath;

  localparam PHT_EntryPath PHT_ENTRY_MAX = '1;

  typedef struct packed {
    logic                   valid;
    AddrPath                brAddr;
    AddrPath                nextAddr;
    logic                   execTaken;
    logic                   isCondBr;
    BranchGlobalHistoryPath globalHistory;
    PHT_EntryPath           phtPrevValue;
  } BranchResult;

  typedef struct packed {
    logic        valid;
    BTB_TagPath  tag;
    BTB_AddrPath data;
    logic        isCondBr;
  } BTB_Entry;

  // Tag is every address bit above the word offset and the BTB index.
  function automatic BTB_TagPath ToBTB_Tag(input AddrPath addr);
    return addr[ADDR_WIDTH-1 -: BTB_TAG_WIDTH];
  endfunction

  function automatic BTB_AddrPath ToBTB_Addr(input AddrPath addr);
    return addr[ADDR_WIDTH-1:2];
  endfunction

endpackage

// File: rtl/branch_update_queue.sv
// Buffers executed-branch updates for the BTB and PHT in two independent FIFOs,
// draining each into its array whenever the fetch-side read leaves it free.
module branch_update_queue
  import branch_update_queue_pkg::*;
#(
  parameter int QUEUE_SIZE      = 32,
  parameter int BTB_INDEX_WIDTH = $clog2(CONF_BTB_ENTRY_NUM),
  parameter int PHT_INDEX_WIDTH = $clog2(CONF_PHT_ENTRY_NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  BranchResult                brResult,
  input  logic                       btbRdBusy,
  input  logic                       phtRdBusy,
  output logic                       btbWE,
  output logic [BTB_INDEX_WIDTH-1:0] btbWA,
  output BTB_Entry                   btbWV,
  output logic                       phtWE,
  output logic [PHT_INDEX_WIDTH-1:0] phtWA,
  output PHT_EntryPath               phtWV,
  output logic                       btbDropped,
  output logic                       phtDropped
);

  localparam int PTR_W = $clog2(QUEUE_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam int GH_COPY = (BRANCH_GLOBAL_HISTORY_BITS < PHT_INDEX_WIDTH) ?
                           BRANCH_GLOBAL_HISTORY_BITS : PHT_INDEX_WIDTH;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_SIZE);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Request formation
  // ---------------------------------------------------------------------------
  logic                       btbReq;
  logic [BTB_INDEX_WIDTH-1:0] btbReqIdx;
  BTB_Entry                   btbReqEntry;

  logic                       phtReq;
  logic [PHT_INDEX_WIDTH-1:0] phtReqIdx;
  logic [PHT_INDEX_WIDTH-1:0] phtHistory;
  PHT_EntryPath               phtReqValue;

  logic unusedLowBits;
  assign unusedLowBits = ^{brResult.brAddr[1:0], brResult.nextAddr[1:0]};

  always_comb begin
    btbReq               = brResult.valid && brResult.execTaken;
    btbReqIdx            = brResult.brAddr[BTB_INDEX_WIDTH+1:2];
    btbReqEntry          = '0;
    btbReqEntry.valid    = 1'b1;
    btbReqEntry.tag      = ToBTB_Tag(brResult.brAddr);
    btbReqEntry.data     = ToBTB_Addr(brResult.nextAddr);
    btbReqEntry.isCondBr = brResult.isCondBr;
  end

  // History is zero-extended or truncated to the PHT index width before hashing.
  always_comb begin
    phtHistory                = '0;
    phtHistory[GH_COPY-1:0]   = brResult.globalHistory[GH_COPY-1:0];
    phtReq                    = brResult.valid && brResult.isCondBr;
    phtReqIdx                 = brResult.brAddr[PHT_INDEX_WIDTH+1:2] ^ phtHistory;
    phtReqValue               = brResult.phtPrevValue;
    if (brResult.execTaken) begin
      if (brResult.phtPrevValue != PHT_ENTRY_MAX) begin
        phtReqValue = brResult.phtPrevValue + PHT_EntryPath'(1);
      end
    end else begin
      if (brResult.phtPrevValue != '0) begin
        phtReqValue = brResult.phtPrevValue - PHT_EntryPath'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // BTB update FIFO
  // ---------------------------------------------------------------------------
  logic [BTB_INDEX_WIDTH-1:0] btbIdxMem   [QUEUE_SIZE];
  BTB_Entry                   btbEntryMem [QUEUE_SIZE];
  logic [PTR_W-1:0]           btbHead;
  logic [PTR_W-1:0]           btbTail;
  logic [CNT_W-1:0]           btbCount;
  logic                       btbFull;
  logic                       btbPush;

  // A full queue still accepts when it drains on the same edge.
  always_comb begin
    btbFull    = (btbCount == FULL_COUNT);
    btbWE      = rst_n && (btbCount != '0) && !btbRdBusy;
    btbPush    = rst_n && btbReq && (!btbFull || btbWE);
    btbDropped = rst_n && btbReq && btbFull && !btbWE;
    btbWA      = btbIdxMem[btbHead];
    btbWV      = btbEntryMem[btbHead];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btbHead  <= '0;
      btbTail  <= '0;
      btbCount <= '0;
    end else begin
      if (btbWE) begin
        btbHead <= btbHead + PTR_ONE;
      end
      if (btbPush) begin
        btbTail <= btbTail + PTR_ONE;
      end
      if (btbPush && !btbWE) begin
        btbCount <= btbCount + CNT_ONE;
      end else if (!btbPush && btbWE) begin
        btbCount <= btbCount - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (btbPush) begin
      btbIdxMem[btbTail]   <= btbReqIdx;
      btbEntryMem[btbTail] <= btbReqEntry;
    end
  end

  // ---------------------------------------------------------------------------
  // PHT update FIFO
  // ---------------------------------------------------------------------------
  logic [PHT_INDEX_WIDTH-1:0] phtIdxMem [QUEUE_SIZE];
  PHT_EntryPath               phtValMem [QUEUE_SIZE];
  logic [PTR_W-1:0]           phtHead;
  logic [PTR_W-1:0]           phtTail;
  logic [CNT_W-1:0]           phtCount;
  logic                       phtFull;
  logic                       phtPush;

  always_comb begin
    phtFull    = (phtCount == FULL_COUNT);
    phtWE      = rst_n && (phtCount != '0) && !phtRdBusy;
    phtPush    = rst_n && phtReq && (!phtFull || phtWE);
    phtDropped = rst_n && phtReq && phtFull && !phtWE;
    phtWA      = phtIdxMem[phtHead];
    phtWV      = phtValMem[phtHead];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phtHead  <= '0;
      phtTail  <= '0;
      phtCount <= '0;
    end else begin
      if (phtWE) begin
        phtHead <= phtHead + PTR_ONE;
      end
      if (phtPush) begin
        phtTail <= phtTail + PTR_ONE;
      end
      if (phtPush && !phtWE) begin
        phtCount <= phtCount + CNT_ONE;
      end else if (!phtPush && phtWE) begin
        phtCount <= phtCount - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (phtPush) begin
      phtIdxMem[phtTail] <= phtReqIdx;
      phtValMem[phtTail] <= phtReqValue;
    end
  end

endmodule
